// File: rtl/meta_test_seq.sv
// meta_test_seq: sequencer that applies an incrementing test pattern to a
// circuit under test. For each trial it waits SETTLE cycles and then samples
// the circuit output. It counts trials and failing trials, and keeps a sticky
// OR of every failing output bit.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         begin a run (accepted only when idle)
//   abort         end the run in progress early
//   num_trials    number of trials in the run (latched on start)
//   seed          first pattern of the run (latched on start)
//   dut_in        registered pattern driven into the circuit under test
//   dut_q         circuit output; any set bit marks the trial as failed
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse when a run ends (normally or by abort)
//   aborted       the last run ended by abort; held until the next start
//   trial_count   trials completed in the current or last run
//   err_count     failing trials in the current or last run
//   err_bits      sticky OR of all failing dut_q samples in the run
module meta_test_seq #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_trials,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_q,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] trial_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] err_bits
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DRIVE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    logic [2:0]       state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [CNT_W-1:0] ntrials_q, ntrials_d;
    logic [CNT_W-1:0] trials_q, trials_d;
    logic [CNT_W-1:0] errs_q, errs_d;
    logic [WIDTH-1:0] ebits_q, ebits_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] trials_inc;

    assign trials_inc = trials_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        pat_d     = pat_q;
        din_d     = din_q;
        ntrials_d = ntrials_q;
        trials_d  = trials_q;
        errs_d    = errs_q;
        ebits_d   = ebits_q;
        aborted_d = aborted_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ntrials_d = num_trials;
                    pat_d     = seed;
                    trials_d  = '0;
                    errs_d    = '0;
                    ebits_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = (num_trials == '0) ? FIN : DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    din_d   = pat_q;
                    wait_d  = SETTLE_CNT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    wait_d = wait_q - 4'd1;
                    // Loaded with SETTLE, so leaving at 1 gives exactly SETTLE cycles here.
                    if (wait_q == 4'd1) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                // An abort here discards the sample entirely.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    trials_d = trials_inc;
                    if (dut_q != '0) begin
                        errs_d  = errs_q + CNT_W'(1);
                        ebits_d = ebits_q | dut_q;
                    end
                    pat_d   = pat_q + WIDTH'(1);
                    state_d = (trials_inc == ntrials_q) ? FIN : DRIVE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            pat_q     <= '0;
            din_q     <= '0;
            ntrials_q <= '0;
            trials_q  <= '0;
            errs_q    <= '0;
            ebits_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            pat_q     <= pat_d;
            din_q     <= din_d;
            ntrials_q <= ntrials_d;
            trials_q  <= trials_d;
            errs_q    <= errs_d;
            ebits_q   <= ebits_d;
            aborted_q <= aborted_d;
        end
    end

    assign dut_in      = din_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign aborted     = aborted_q;
    assign trial_count = trials_q;
    assign err_count   = errs_q;
    assign err_bits    = ebits_q;

endmodule

// File: doc/meta_test_seq.md
META_TEST_SEQ -- requirements
Module: meta_test_seq

Interface
REQ-001 Parameter WIDTH, 4, width of the test pattern and of the checked output vector.
REQ-002 Parameter CNT_W, 16, width of the trial and error counters.
REQ-003 Parameter SETTLE, 2, wait cycles between driving a pattern and sampling the circuit output; legal range 1..15.
REQ-004 clk  in  1  single clock; all state SHALL update on posedge clk only.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  single-cycle request to begin a test run; sampled only in IDLE.
REQ-007 abort  in  1  terminates a run in progress.
REQ-008 num_trials  in  CNT_W  trial count for the run; latched on accepted start.
REQ-009 seed  in  WIDTH  first pattern of the run; latched on accepted start.
REQ-010 dut_in  out  WIDTH  registered pattern driven into the circuit under test.
REQ-011 dut_q  in  WIDTH  circuit-under-test output; all-zero means pass, any 1 bit means fail.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at end of run.
REQ-014 aborted  out  1  set when the run ended by abort; held until next accepted start.
REQ-015 trial_count  out  CNT_W  trials completed in current/last run.
REQ-016 err_count  out  CNT_W  trials whose sampled dut_q was nonzero.
REQ-017 err_bits  out  WIDTH  sticky OR of all failing dut_q samples in the run.

Function
REQ-018 FSM states SHALL be IDLE, DRIVE, WAIT, CHECK, FIN.
REQ-019 IDLE: start=1 SHALL latch num_trials and seed, clear trial_count, err_count, err_bits and aborted, and go to DRIVE; if latched num_trials=0, go to FIN instead.
REQ-020 start while busy=1 SHALL be ignored with no effect.
REQ-021 DRIVE: dut_in SHALL load the current pattern, wait counter SHALL load SETTLE, next state WAIT (one cycle in DRIVE).
REQ-022 WAIT: counter decrements each cycle; WAIT SHALL last exactly SETTLE cycles, then go to CHECK.
REQ-023 CHECK (one cycle): if dut_q!=0, err_count increments by 1 and err_bits |= dut_q; trial_count increments by 1 in all cases.
REQ-024 CHECK: pattern SHALL advance to pattern+1 modulo 2^WIDTH (e.g. 4'hF wraps to 4'h0).
REQ-025 CHECK: if the incremented trial_count equals num_trials, go to FIN; otherwise go to DRIVE.
REQ-026 Per-trial latency SHALL be SETTLE+2 cycles; a run of N trials SHALL assert done exactly N*(SETTLE+2)+1 cycles after the start cycle.
REQ-027 FIN: done=1 for exactly one cycle, then IDLE; counters and err_bits SHALL hold until the next accepted start.
REQ-028 abort=1 in DRIVE, WAIT or CHECK SHALL go to FIN and set aborted; a CHECK coinciding with abort SHALL NOT update any counter.
REQ-029 abort in IDLE or FIN SHALL be ignored.
REQ-030 dut_in SHALL hold its value outside DRIVE, including in IDLE after a run.
REQ-031 err_count SHALL never exceed trial_count, and no counter SHALL wrap, because trial_count <= num_trials <= 2^CNT_W-1.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE and set dut_in, trial_count, err_count, err_bits to 0 and busy, done, aborted to 0, regardless of state.
REQ-033 rst SHALL take priority over start and abort in the same cycle; a run interrupted by rst SHALL NOT produce done.

Verification
REQ-034 Ideal circuit (dut_q=0 always), seed=4'h3, num_trials=5, SETTLE=2 -> dut_in sequence 3,4,5,6,7; done 21 cycles after start; trial_count=5, err_count=0, err_bits=0.
REQ-035 Circuit model forcing dut_q=4'b0100 on the 2nd trial and 4'b0001 on the 4th, num_trials=6 -> err_count=2, err_bits=4'b0101, trial_count=6.
REQ-036 seed=4'hE, num_trials=4 -> dut_in sequence E,F,0,1 (wrap).
REQ-037 start with num_trials=0 -> busy for 1 cycle, done pulse, all counters 0, dut_in unchanged.
REQ-038 abort asserted during WAIT of trial 3 of 10 -> done next cycle, aborted=1, trial_count=2; a second start during the run is ignored.
REQ-039 rst pulsed mid-CHECK of trial 4 -> IDLE next cycle, all outputs 0, no done pulse; a fresh start then runs normally.
